// File: rtl/mul_pkg.sv
// Shared multiplier definitions: opcode encoding and result-word selection.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_W   = 2'd0,
    MULH_W  = 2'd1,
    MULH_WU = 2'd2,
    RSVD    = 2'd3
  } mul_op_t;

  // High-word ops take product[63:32]. Signedness was already folded in upstream.
  function automatic logic selects_high(mul_op_t op);
    return (op == MULH_W) || (op == MULH_WU);
  endfunction

endpackage

// File: rtl/mul_final_add_if.sv
// Carry-save input and selected-result output bundle between the multiplier and writeback.
interface mul_final_add_if #(parameter int XLEN = 32);
  import mul_pkg::*;

  logic              in_valid;
  mul_op_t           in_op;
  logic [4:0]        in_rd;
  logic [2*XLEN-1:0] in_tmp1;
  logic [2*XLEN-1:0] in_tmp2;

  logic              out_valid;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_result;

  modport master (
    output in_valid, in_op, in_rd, in_tmp1, in_tmp2,
    input  out_valid, out_rd, out_result
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_tmp1, in_tmp2,
    output out_valid, out_rd, out_result
  );
endinterface

// File: rtl/add32_c.sv
// Word-wide adder with carry-in and carry-out; one half of the 64-bit resolve.
module add32_c #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mul_final_add.sv
// Two-stage carry-propagate resolve of the multiplier's carry-save pair, followed by
// low/high word selection. Stage A adds the low halves, stage B adds the high halves
// with the low carry and holds the selected word for writeback.
module mul_final_add
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  input  logic           stall,
  mul_final_add_if.slave bus,
  output logic           busy
);

  logic [XLEN-1:0] lo_sum;
  logic            lo_cout;
  logic [XLEN-1:0] hi_sum;
  logic            hi_cout_unused;

  logic            a_valid;
  logic [XLEN-1:0] a_lo;
  logic            a_c32;
  logic [XLEN-1:0] a_hi1;
  logic [XLEN-1:0] a_hi2;
  mul_op_t         a_op;
  logic [4:0]      a_rd;

  logic            b_valid;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_result;

  add32_c #(.W(XLEN)) u_add_lo (
    .a    (bus.in_tmp1[XLEN-1:0]),
    .b    (bus.in_tmp2[XLEN-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // The product wraps modulo 2^64, so the top carry-out is discarded.
  add32_c #(.W(XLEN)) u_add_hi (
    .a    (a_hi1),
    .b    (a_hi2),
    .cin  (a_c32),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  // Stage A: capture the low sum, its carry and the untouched high halves.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_valid <= 1'b0;
      a_lo    <= '0;
      a_c32   <= 1'b0;
      a_hi1   <= '0;
      a_hi2   <= '0;
      a_op    <= MUL_W;
      a_rd    <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (!stall) begin
      a_valid <= bus.in_valid;
      if (bus.in_valid) begin
        a_lo  <= lo_sum;
        a_c32 <= lo_cout;
        a_hi1 <= bus.in_tmp1[2*XLEN-1:XLEN];
        a_hi2 <= bus.in_tmp2[2*XLEN-1:XLEN];
        a_op  <= bus.in_op;
        a_rd  <= bus.in_rd;
      end
    end
  end

  // Stage B: finish the high half and latch the word the opcode asks for.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      b_valid  <= 1'b0;
      b_rd     <= '0;
      b_result <= '0;
    end else if (flush) begin
      b_valid <= 1'b0;
    end else if (!stall) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_rd     <= a_rd;
        b_result <= selects_high(a_op) ? hi_sum : a_lo;
      end
    end
  end

  assign bus.out_valid  = b_valid;
  assign bus.out_rd     = b_rd;
  assign bus.out_result = b_result;
  assign busy           = a_valid | b_valid;

endmodule

// File: doc/mul_final_add.md
# mul_final_add

Two-stage pipelined carry-propagate adder and result selector at the output of the EX multiplier. It consumes the 64-bit carry-save pair (sum, shifted carry) produced in the multiplier's second EX cycle and resolves it to a 64-bit product over two clock cycles. It then selects the low or high 32-bit word per opcode and presents the result, tagged with its destination register, to the MEM/WB writeback path. Pipeline stall and CSR flush are honoured at every stage.

## Interface
Parameters:
- XLEN, 32, architectural result width; internal product is 2*XLEN.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  WB CSR flush; kills all in-flight entries
- stall  in  1  downstream pipeline stall; freezes both stages
- in_valid  in  1  carry-save pair valid this cycle (multiplier's second EX cycle)
- in_op  in  2  mul_op_t: MUL_W=0, MULH_W=1, MULH_WU=2, 3 reserved
- in_rd  in  5  destination register tag
- in_tmp1  in  64  carry-save sum
- in_tmp2  in  64  carry-save carry, already shifted left by 1
- out_valid  out  1  result valid
- out_rd  out  5  destination tag of result
- out_result  out  32  selected product word
- busy  out  1  any stage holds a valid entry

## Operation
- Stage A, captured on a clock with in_valid & ~stall & ~flush:
  - lo_sum = tmp1[31:0] + tmp2[31:0]; register 32-bit sum and carry-out c32.
  - Register tmp1[63:32], tmp2[63:32], op, rd; set a_valid.
- Stage B, captured on a clock with a_valid & ~stall & ~flush:
  - hi_sum = tmp1_hi + tmp2_hi + c32, truncated to 32 bits (product wraps modulo 2^64).
  - Result selection: MUL_W uses lo_sum. MULH_W and MULH_WU use hi_sum. Signedness is already encoded upstream, so both high ops add identically.
  - Reserved op 3 behaves as MUL_W.
- Outputs are driven directly from stage B registers: out_valid=b_valid, out_rd, out_result.
- busy = a_valid | b_valid.
- Stall: all registers, including valids, hold their values. in_valid during stall is ignored; the producer must hold it.
- When not stalled, a_valid updates every cycle: no in_valid clears it, so no bubble leaks into B as a duplicate.
- Flush: a_valid and b_valid clear on the next edge. Data registers need not clear. Flush has priority over stall and in_valid.
- Reset: a_valid=b_valid=0. All data registers are 0, so out_valid=0, out_rd=0, out_result=0 after reset.

## Timing
- Latency: in_valid sampled at edge N produces out_valid high after edge N+1, i.e. the result is visible during cycle N+1 to N+2.
- Throughput: one result per cycle when unstalled. Back-to-back inputs are legal, although the multiplier issues at most one every 2 cycles.
- Stall asserted for k cycles freezes out_valid/out_result for k+1 visible cycles. The result is consumed on the first unstalled edge.
- flush and stall together: flush wins, and both valids are 0 after the edge.
- in_valid and flush together: the input is dropped.
- Reset mid-operation: identical to flush, and it also zeroes the data registers.

## Structure
- Put mul_op_t (2-bit enum: MUL_W, MULH_W, MULH_WU, RSVD) in shared package mul_pkg. The decoder and multiplier import the same definition.
- Use one sub-module, add32_c: a 32-bit adder with carry-in and carry-out. It is instantiated twice: stage A with cin=0, stage B with cin=c32.
- No state machine. The block is two valid-qualified pipeline registers with a shared stall-enable and flush-clear.

## Test plan
- Basic low: tmp1=0x0000_0000_0000_000F, tmp2=0, op MUL_W, rd=5 -> two cycles later out_valid=1, out_rd=5, out_result=0x0000000F.
- Carry across halves: tmp1=0x0000_0000_FFFF_FFFF, tmp2=0x0000_0000_0000_0001, op MULH_W -> out_result=0x00000001. The same inputs with op MUL_W -> 0x00000000.
- Wrap and signed high: tmp1=0xFFFF_FFFF_FFFF_FFFF, tmp2=0x0000_0000_0000_0002, op MULH_WU -> out_result=0x00000000 (64-bit sum 1). With op MUL_W -> 0x00000001.
- Stall hold: issue op MUL_W, value 7, then assert stall for 3 cycles once it reaches stage B -> out_valid=1 and out_result=7 are constant for 4 cycles. No duplicate appears after the stall releases.
- Flush: issue two back-to-back entries, assert flush together with stall on the next cycle -> out_valid=0 and busy=0 after the edge. Neither result ever appears.
- Reset mid-flight: assert rstn=0 with both stages valid -> after one edge out_valid=0, out_rd=0, out_result=0, busy=0.
